button_debouncer: RTL and testbench

Conditions a raw mechanical push-button input into a clean, glitch-free level plus single-cycle press/release pulses. It sits between the board pin and the button-driven colour/mode state machine, which advances on one `pressed` pulse per physical press. Internally: a two-flop synchronizer feeding a four-state debounce FSM with a stability counter.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/synchronizer.sv | 34 +++
 rtl/button_debouncer.sv | 150 +++++++++++++++
 tb/tb_button_debouncer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the push-button debounce path.
//   debounce_state_t       : four-state debounce FSM encoding (2 bits)
//   DEBOUNCE_DEFAULT_TICKS : default number of stable cycles to accept a level
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW,
        MAYBE_HIGH,
        STABLE_HIGH,
        MAYBE_LOW
    } debounce_state_t;

    localparam int DEBOUNCE_DEFAULT_TICKS = 16;

endpackage : debounce_pkg

// File: rtl/synchronizer.sv
// -----------------------------------------------------------------------------
// synchronizer
// Multi-flop synchronizer that brings an asynchronous pin into the clk domain.
// STAGES must be at least 2.
// Ports:
//   clk    in  sampling clock
//   rst_n  in  asynchronous active-low reset, all stages clear to 0
//   d_i    in  asynchronous input
//   q_o    out synchronized output (STAGES cycles of latency)
// -----------------------------------------------------------------------------
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : synchronizer

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Turns a bouncing mechanical button pin into a clean level plus one-cycle
// press/release pulses. The pin is normalised (optionally inverted), passed
// through a 2-flop synchronizer, and qualified by a four-state FSM that needs
// BOUNCE_TICKS consecutive stable cycles before accepting a level change.
// Parameters:
//   BOUNCE_TICKS  stable cycles needed to accept a change (>= 2)
//   ACTIVE_LOW    1 when the pin reads 0 while pressed
// Ports:
//   clk         in  sole clock
//   rst         in  asynchronous active-low reset
//   ena         in  FSM/counter advance enable (synchronizer always runs)
//   button_raw  in  asynchronous pin input
//   button_out  out debounced level, 1 = pressed
//   pressed     out one-cycle pulse on an accepted press
//   released    out one-cycle pulse on an accepted release
// -----------------------------------------------------------------------------
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int BOUNCE_TICKS = DEBOUNCE_DEFAULT_TICKS,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic button_raw,
    output logic button_out,
    output logic pressed,
    output logic released
);

    localparam int             CNT_W    = $clog2(BOUNCE_TICKS);
    // Last count value of a qualification window; the counter never passes it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOUNCE_TICKS - 1);

    logic btn_n;
    logic btn_s;

    debounce_state_t    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               pressed_q, pressed_d;
    logic               released_q, released_d;

    // After normalisation 1 always means "pressed".
    assign btn_n = button_raw ^ ACTIVE_LOW;

    synchronizer #(
        .STAGES (2)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (btn_n),
        .q_o   (btn_s)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;

        // With ena low everything holds, so a MAYBE_* count freezes and
        // btn_s is ignored until ena returns.
        if (ena) begin
            case (state_q)
                STABLE_LOW: begin
                    if (btn_s) begin
                        state_d = MAYBE_HIGH;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end

                MAYBE_HIGH: begin
                    if (!btn_s) begin
                        // Bounce: abort silently to the prior stable level.
                        state_d = STABLE_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = STABLE_HIGH;
                        cnt_d     = '0;
                        out_d     = 1'b1;
                        pressed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                STABLE_HIGH: begin
                    if (!btn_s) begin
                        state_d = MAYBE_LOW;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end

                MAYBE_LOW: begin
                    if (btn_s) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d    = STABLE_LOW;
                        cnt_d      = '0;
                        out_d      = 1'b0;
                        released_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                end
            endcase
        end
    end

    // NOTE: outputs come straight from flops with an asynchronous clear, so
    // reset forces them to 0 immediately without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= STABLE_LOW;
            cnt_q      <= '0;
            out_q      <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign button_out = out_q;
    assign pressed    = pressed_q;
    assign released   = released_q;

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
// Drives two debouncers (active-high and active-low pin) with BOUNCE_TICKS=4.
// Each stimulus step pushes the expected pulse (cycle, kind, instance) into a
// scoreboard queue; a negedge monitor pops and compares whenever a pulse shows.
// Edge numbering: cyc holds the index of the most recent rising edge.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int BT = 4;

    typedef struct {
        int cyc;
        bit press;
        bit inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic raw0, raw1;
    logic bo0, pr0, rl0;
    logic bo1, pr1, rl1;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_debouncer #(.BOUNCE_TICKS(BT), .ACTIVE_LOW(1'b0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .button_raw (raw0),
        .button_out (bo0),
        .pressed    (pr0),
        .released   (rl0)
    );

    button_debouncer #(.BOUNCE_TICKS(BT), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .button_raw (raw1),
        .button_out (bo1),
        .pressed    (pr1),
        .released   (rl1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int at, input bit press, input bit inst);
        exp_t e;
        e.cyc   = at;
        e.press = press;
        e.inst  = inst;
        sb.push_back(e);
    endtask

    task automatic mon(input bit inst, input logic p, input logic r, input logic lvl);
        exp_t e;
        if (p || r) begin
            check("pulse_exclusive", 32'(p & r), 0);
            if (sb.size() == 0) begin
                check("pulse_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_cyc", cyc, e.cyc);
                check("pulse_kind", 32'(p), 32'(e.press));
                check("pulse_inst", 32'(inst), 32'(e.inst));
                check("level_with_pulse", 32'(lvl), 32'(p));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, pr0, rl0, bo0);
        mon(1'b1, pr1, rl1, bo1);
    end

    // Watchdog: the run is fixed-length, this only guards against a stall.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst  = 1'b0;
        ena  = 1'b1;
        raw0 = 1'b0;
        raw1 = 1'b1;   // active-low pin idles high

        // Reset state, before any clock edge
        #3;
        check("rst_out0", 32'(bo0), 0);
        check("rst_pressed0", 32'(pr0), 0);
        check("rst_released0", 32'(rl0), 0);
        check("rst_out1", 32'(bo1), 0);

        tick(3);
        rst = 1'b1;

        // Clean press: raise just before edge 10 -> pulse after edge 15
        while (cyc < 9) @(negedge clk);
        raw0 = 1'b1;
        expect_pulse(cyc + BT + 2, 1'b1, 1'b0);
        tick(BT + 2);
        check("press_level", 32'(bo0), 1);
        tick(1);
        check("press_single", 32'(pr0), 0);
        tick(4);

        // Clean release
        raw0 = 1'b0;
        expect_pulse(cyc + BT + 2, 1'b0, 1'b0);
        tick(BT + 1);
        check("release_before", 32'(bo0), 1);
        tick(1);
        check("release_level", 32'(bo0), 0);
        tick(4);

        // Bounce rejection: 2-cycle pulses, then hold high
        for (int i = 0; i < 4; i++) begin
            raw0 = ~raw0;
            tick(2);
        end
        raw0 = 1'b1;
        expect_pulse(cyc + BT + 2, 1'b1, 1'b0);
        tick(BT + 1);
        check("bounce_no_early", 32'(bo0), 0);
        tick(5);
        raw0 = 1'b0;
        expect_pulse(cyc + BT + 2, 1'b0, 1'b0);
        tick(10);

        // Enable freeze for 5 cycles after 2 counts -> pulse 5 cycles late
        c    = cyc;
        raw0 = 1'b1;
        expect_pulse(c + BT + 2 + 5, 1'b1, 1'b0);
        tick(4);
        ena = 1'b0;
        tick(5);
        check("freeze_hold", 32'(bo0), 0);
        ena = 1'b1;
        tick(10);
        raw0 = 1'b0;
        expect_pulse(cyc + BT + 2, 1'b0, 1'b0);
        tick(10);

        // Active-low pin: drop to 0 -> press, back to 1 -> release
        raw1 = 1'b0;
        expect_pulse(cyc + BT + 2, 1'b1, 1'b1);
        tick(10);
        check("al_level", 32'(bo1), 1);
        raw1 = 1'b1;
        expect_pulse(cyc + BT + 2, 1'b0, 1'b1);
        tick(10);

        // Reset mid-count (inst1) and while pressed (inst0); both held through
        raw0 = 1'b1;
        expect_pulse(cyc + BT + 2, 1'b1, 1'b0);
        tick(10);
        raw1 = 1'b0;
        tick(3);
        #2 rst = 1'b0;
        #1;
        check("midrst_out0", 32'(bo0), 0);
        check("midrst_rel0", 32'(rl0), 0);
        check("midrst_out1", 32'(bo1), 0);
        check("midrst_pr1", 32'(pr1), 0);
        tick(2);
        rst = 1'b1;
        expect_pulse(cyc + BT + 2, 1'b1, 1'b0);
        expect_pulse(cyc + BT + 2, 1'b1, 1'b1);
        tick(BT + 1);
        check("requal_out0", 32'(bo0), 0);
        check("requal_out1", 32'(bo1), 0);
        tick(6);
        check("requal_done1", 32'(bo1), 1);

        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_button_debouncer
